ili9488_fill_engine: RTL
========================

# ili9488_fill_engine

Full-screen fill engine for the ILI9488 over the 16-bit 8080-I parallel bus. It sets the column and page window to the full panel, issues Memory Write (0x2C), and streams H_RES×V_RES RGB565 pixels of one color. It then raises fill_done, which the color generator consumes. reset_done restarts the engine for the next color.

## Interface
- H_RES, 320: panel columns; column window is 0..H_RES-1.
- V_RES, 480: panel rows; page window is 0..V_RES-1.
- WR_HALF, 1: clk cycles per write-strobe phase (low phase and high phase each), ≥1.
- clk  in  1  system clock; all outputs are registered on its rising edge.
- reset_done  in  1  reset reset_done, asynchronous, active-high; aborts any fill; a fill starts automatically after release.
- color  in  16  RGB565 fill color; sampled once per fill.
- lcd_cs_n  out  1  chip select, active-low.
- lcd_dc  out  1  0 = command, 1 = parameter/pixel data.
- lcd_wr_n  out  1  write strobe; panel latches on rising edge.
- lcd_rd_n  out  1  constant 1.
- lcd_data  out  16  bus data.
- fill_done  out  1  high once all pixels are written; held until reset_done.

## Operation
- States: IDLE → CMD → PIX → DONE.
- IDLE: one cycle after reset release; latches color into color_q; next state CMD.
- CMD: sends an 11-entry write sequence from an internal ROM, in order (dc, data):
  - (0,0x002A), (1,0x0000), (1,0x0000), (1,(H_RES-1)>>8), (1,(H_RES-1)&0xFF)
  - (0,0x002B), (1,0x0000), (1,0x0000), (1,(V_RES-1)>>8), (1,(V_RES-1)&0xFF)
  - (0,0x002C)
  - Commands and parameters use the low byte only; upper byte is 0.
- PIX: H_RES×V_RES writes with dc=1 and data=color_q.
  - Pixel counter width is $clog2(H_RES*V_RES+1).
  - Counter runs 0..N-1 with no wrap; on the final write's high-phase end, go to DONE.
- DONE: cs_n=1, wr_n=1, dc=0, data=0, fill_done=1. Stays here until reset_done; no further bus activity.
- Changes on color during CMD/PIX/DONE are ignored; only the IDLE sample counts.
- Reset mid-operation (any state): outputs go to reset values immediately (asynchronous). After release the sequence restarts from ROM entry 0; no partial resume.

## Timing
- Reset values: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_dc=0, lcd_data=0, fill_done=0.
- Write slot: 2×WR_HALF cycles.
  - Low phase: wr_n=0, dc and data valid, for WR_HALF cycles.
  - High phase: wr_n=1, dc and data unchanged, for WR_HALF cycles.
  - dc/data change only at slot boundaries (with wr_n falling). This gives ≥WR_HALF cycles setup and hold around the wr_n rising edge.
- lcd_cs_n falls together with the first wr_n fall and stays low continuously through the last pixel. It rises on the cycle DONE is entered.
- First wr_n fall: 2nd rising clk edge after reset release (cycle 0 IDLE, cycle 1 first low phase).
- Total: 1 + (11 + H_RES×V_RES)×2×WR_HALF cycles from release to fill_done=1. Default params: 1 + 153611×2 = 307223 cycles.
- fill_done rises in the same cycle lcd_cs_n rises.

## Test plan
- H_RES=4, V_RES=2, WR_HALF=1, color=0xF800. Release reset → exactly 19 wr_n rising edges:
  - dc sequence 0,1,1,1,1,0,1,1,1,1,0 then eight 1s.
  - data 0x2A,0,0,0,0x03,0x2B,0,0,0,0x01,0x2C then 8×0xF800.
  - fill_done=1 at cycle 39; cs_n low for cycles 1..38.
- Default params: count pixel writes = 153600. Window parameters are 0x01,0x3F (columns) and 0x01,0xDF (rows).
- WR_HALF=3: every wr_n low and high phase lasts exactly 3 cycles. data is stable 3 cycles before and 3 cycles after each wr_n rising edge.
- Color sampling: change color from 0x07E0 to 0x001F during PIX → all pixels are 0x07E0. Pulse reset_done → next fill uses 0x001F.
- Reset mid-fill (async, between clock edges, during pixel 3): outputs return to reset values without waiting for a clock edge. After release the first write is (0,0x002A) and fill_done stays 0 until the full count completes.
- DONE hold: run 1000 cycles after fill_done → fill_done stays 1, wr_n stays 1, cs_n stays 1, no bus toggles.

Source files
------------

// File: rtl/ili9488_fill_engine.sv
// ili9488_fill_engine
// Fills the whole ILI9488 panel with one RGB565 color over the 16-bit 8080-I
// bus: full-panel column/page window, Memory Write, then H_RES*V_RES pixels.
// The sequencer runs one cycle ahead of the registered bus outputs, so the
// bus always shows what the sequencer decided on the previous cycle.
module ili9488_fill_engine #(
   parameter int H_RES   = 320,
   parameter int V_RES   = 480,
   parameter int WR_HALF = 1
) (
   input  logic        clk,
   input  logic        reset_done,
   input  logic [15:0] color,
   output logic        lcd_cs_n,
   output logic        lcd_dc,
   output logic        lcd_wr_n,
   output logic        lcd_rd_n,
   output logic [15:0] lcd_data,
   output logic        fill_done
);

   localparam int N_PIX  = H_RES * V_RES;
   localparam int PIX_W  = $clog2(N_PIX + 1);
   localparam int HALF_W = (WR_HALF > 1) ? $clog2(WR_HALF) : 1;

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(N_PIX - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(WR_HALF - 1);
   localparam logic [15:0]       H_LAST    = 16'(H_RES - 1);
   localparam logic [15:0]       V_LAST    = 16'(V_RES - 1);
   localparam logic [3:0]        ROM_LAST  = 4'd10;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMD  = 2'd1;
   localparam logic [1:0] S_PIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Setup ROM: {dc, data}; commands and parameters carry only a low byte.
   function automatic logic [16:0] rom_entry(input logic [3:0] idx);
      logic [16:0] e;
      case (idx)
         4'd0:    e = {1'b0, 16'h002A};
         4'd1:    e = {1'b1, 16'h0000};
         4'd2:    e = {1'b1, 16'h0000};
         4'd3:    e = {1'b1, 8'h00, H_LAST[15:8]};
         4'd4:    e = {1'b1, 8'h00, H_LAST[7:0]};
         4'd5:    e = {1'b0, 16'h002B};
         4'd6:    e = {1'b1, 16'h0000};
         4'd7:    e = {1'b1, 16'h0000};
         4'd8:    e = {1'b1, 8'h00, V_LAST[15:8]};
         4'd9:    e = {1'b1, 8'h00, V_LAST[7:0]};
         4'd10:   e = {1'b0, 16'h002C};
         default: e = 17'h0;
      endcase
      return e;
   endfunction

   logic [1:0]        state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic [HALF_W-1:0] half_q, half_d;
   logic              phase_q, phase_d;     // 0 = wr_n low phase, 1 = high phase
   logic [15:0]       color_q, color_d;
   logic              cs_n_q, cs_n_d;
   logic              dc_q, dc_d;
   logic              wr_n_q, wr_n_d;
   logic [15:0]       data_q, data_d;
   logic              done_q, done_d;
   logic [16:0]       bus_word;
   logic              phase_end;

   // Sequencer and next-output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pix_d     = pix_q;
      half_d    = half_q;
      phase_d   = phase_q;
      color_d   = color_q;
      cs_n_d    = cs_n_q;
      dc_d      = dc_q;
      wr_n_d    = wr_n_q;
      data_d    = data_q;
      done_d    = done_q;
      bus_word  = (state_q == S_CMD) ? rom_entry(idx_q) : {1'b1, color_q};
      phase_end = (half_q == HALF_LAST);
      case (state_q)
         S_IDLE: begin
            color_d = color;
            idx_d   = 4'd0;
            pix_d   = '0;
            half_d  = '0;
            phase_d = 1'b0;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            dc_d    = 1'b0;
            data_d  = 16'h0;
            done_d  = 1'b0;
            state_d = S_CMD;
         end
         S_CMD, S_PIX: begin
            // The word is constant for a whole slot, so dc/data only move
            // together with the wr_n fall that opens the next slot.
            cs_n_d = 1'b0;
            wr_n_d = phase_q;
            dc_d   = bus_word[16];
            data_d = bus_word[15:0];
            if (phase_end) begin
               half_d  = '0;
               phase_d = ~phase_q;
            end else begin
               half_d = half_q + HALF_W'(1);
            end
            if (phase_end && phase_q) begin
               if (state_q == S_CMD) begin
                  if (idx_q == ROM_LAST) state_d = S_PIX;
                  else                   idx_d   = idx_q + 4'd1;
               end else begin
                  if (pix_q == PIX_LAST) state_d = S_DONE;
                  else                   pix_d   = pix_q + PIX_W'(1);
               end
            end
         end
         S_DONE: begin
            cs_n_d = 1'b1;
            wr_n_d = 1'b1;
            dc_d   = 1'b0;
            data_d = 16'h0;
            done_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset returns the bus to idle at once.
   always_ff @(posedge clk or posedge reset_done) begin
      if (reset_done) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         pix_q   <= '0;
         half_q  <= '0;
         phase_q <= 1'b0;
         color_q <= 16'h0;
         cs_n_q  <= 1'b1;
         dc_q    <= 1'b0;
         wr_n_q  <= 1'b1;
         data_q  <= 16'h0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pix_q   <= pix_d;
         half_q  <= half_d;
         phase_q <= phase_d;
         color_q <= color_d;
         cs_n_q  <= cs_n_d;
         dc_q    <= dc_d;
         wr_n_q  <= wr_n_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign lcd_cs_n  = cs_n_q;
   assign lcd_dc    = dc_q;
   assign lcd_wr_n  = wr_n_q;
   assign lcd_rd_n  = 1'b1;
   assign lcd_data  = data_q;
   assign fill_done = done_q;

endmodule
